// File: rtl/clic_target_pipe.sv
// CLIC interrupt target: per-source eligibility, {mode, prio} max tree, optional
// root pipeline and a valid/ready/kill handshake towards the hart.
module clic_target_pipe #(
  parameter int N_SOURCE  = 256,
  parameter int N_PIPE    = 1,
  parameter int PrioWidth = 8,
  parameter int ModeWidth = 2,
  localparam int SrcWidth = $clog2(N_SOURCE)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_SOURCE-1:0]                 ip_i,
  input  logic [N_SOURCE-1:0]                 ie_i,
  input  logic [N_SOURCE-1:0]                 le_i,
  input  logic [N_SOURCE-1:0]                 shv_i,
  input  logic [N_SOURCE-1:0][PrioWidth-1:0]  prio_i,
  input  logic [N_SOURCE-1:0][ModeWidth-1:0]  mode_i,
  input  logic [PrioWidth-1:0]                thresh_i,
  output logic [N_SOURCE-1:0]                 claim_o,
  output logic                                irq_valid_o,
  input  logic                                irq_ready_i,
  output logic [SrcWidth-1:0]                 irq_id_o,
  output logic [PrioWidth-1:0]                irq_max_o,
  output logic [ModeWidth-1:0]                irq_mode_o,
  output logic                                irq_shv_o,
  output logic                                irq_kill_req_o,
  input  logic                                irq_kill_ack_i
);

  localparam int NLeaf  = 2 ** SrcWidth;
  localparam int NNodes = 2 * NLeaf - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK   = 2'd1;
  localparam logic [1:0] CLAIM = 2'd2;

  typedef struct packed {
    logic                 vld;
    logic [SrcWidth-1:0]  id;
    logic [ModeWidth-1:0] mode;
    logic [PrioWidth-1:0] prio;
    logic                 shv;
  } cand_t;

  if (N_PIPE < 0 || N_PIPE > 4 || N_SOURCE < 2) begin : g_param_check
    $error("clic_target_pipe: N_PIPE must be 0..4 and N_SOURCE at least 2");
  end

  cand_t leaf [NLeaf];
  cand_t node [NNodes];
  cand_t root_s;
  cand_t head_s;
  logic  flush_s;

  for (genvar s = 0; s < NLeaf; s++) begin : g_leaf
    if (s < N_SOURCE) begin : g_src
      assign leaf[s] = '{vld:  ip_i[s] & ie_i[s] & (prio_i[s] > thresh_i),
                         id:   SrcWidth'(s),
                         mode: mode_i[s],
                         prio: prio_i[s],
                         shv:  shv_i[s]};
    end else begin : g_pad
      assign leaf[s] = '0;
    end
  end

  // Heap-ordered max tree: left subtree holds lower ids, so it wins on equal keys.
  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < NLeaf; i++) begin
      node[NLeaf - 1 + i] = leaf[i];
    end
    for (int i = NLeaf - 2; i >= 0; i--) begin
      if (node[2*i+1].vld &&
          (!node[2*i+2].vld ||
           ({node[2*i+1].mode, node[2*i+1].prio} >= {node[2*i+2].mode, node[2*i+2].prio}))) begin
        node[i] = node[2*i+1];
      end else begin
        node[i] = node[2*i+2];
      end
    end
  end

  assign root_s = node[0];

  if (N_PIPE == 0) begin : g_no_pipe
    assign head_s = root_s;
  end else begin : g_pipe
    cand_t pipe_d [N_PIPE];
    cand_t pipe_q [N_PIPE];

    // A claim flushes every stage so an already-served winner is never re-presented.
    always_comb begin
      pipe_d[0] = flush_s ? '0 : root_s;
      for (int i = 1; i < N_PIPE; i++) begin
        pipe_d[i] = flush_s ? '0 : pipe_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign head_s = pipe_q[N_PIPE-1];
  end

  logic [1:0]          state_d, state_q;
  cand_t               out_d, out_q;
  logic                kill_d, kill_q;
  logic [N_SOURCE-1:0] claim_d, claim_q;
  logic                kill_cond_s;

  assign flush_s     = (state_q == CLAIM);
  assign kill_cond_s = (head_s.vld && (head_s.id != out_q.id)) || (out_q.prio <= thresh_i);

  // out_q.vld is irq_valid_o; attributes are zero whenever the FSM rests in IDLE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    kill_d  = 1'b0;
    claim_d = '0;
    case (state_q)
      IDLE: begin
        if (head_s.vld) begin
          state_d = ACK;
          out_d   = head_s;
        end else begin
          out_d   = '0;
        end
      end
      ACK: begin
        if (!le_i[out_q.id] && !ip_i[out_q.id]) begin
          state_d = IDLE;
          out_d   = '0;
        end else if (out_q.vld && irq_ready_i) begin
          state_d   = CLAIM;
          out_d.vld = 1'b0;
        end else if (kill_q && irq_kill_ack_i) begin
          state_d = IDLE;
          out_d   = '0;
        end else begin
          kill_d  = kill_cond_s;
        end
      end
      CLAIM: begin
        claim_d[out_q.id] = 1'b1;
        state_d           = IDLE;
        out_d             = '0;
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
      kill_q  <= 1'b0;
      claim_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      kill_q  <= kill_d;
      claim_q <= claim_d;
    end
  end

  assign irq_valid_o    = out_q.vld;
  assign irq_id_o       = out_q.id;
  assign irq_max_o      = out_q.prio;
  assign irq_mode_o     = out_q.mode;
  assign irq_shv_o      = out_q.shv;
  assign irq_kill_req_o = kill_q;
  assign claim_o        = claim_q;

endmodule

// File: tb/tb_clic_target_pipe.sv
// Self-checking bench for clic_target_pipe: directed handshake scenarios plus a
// randomized run against a behavioural reference model.
module tb_clic_target_pipe;

  localparam int NS = 16;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   ip, ie, le, shv;
  logic [NS-1:0][7:0] prio;
  logic [NS-1:0][1:0] mode;
  logic [7:0]      thresh;
  logic            ready, kill_ack;
  logic [NS-1:0]   claim_o;
  logic            irq_valid_o, irq_shv_o, irq_kill_req_o;
  logic [3:0]      irq_id_o;
  logic [7:0]      irq_max_o;
  logic [1:0]      irq_mode_o;

  int n_checks = 0;
  int n_pass   = 0;

  clic_target_pipe #(.N_SOURCE(NS), .N_PIPE(NP), .PrioWidth(8), .ModeWidth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ip_i(ip), .ie_i(ie), .le_i(le), .shv_i(shv),
    .prio_i(prio), .mode_i(mode), .thresh_i(thresh), .claim_o(claim_o),
    .irq_valid_o(irq_valid_o), .irq_ready_i(ready), .irq_id_o(irq_id_o),
    .irq_max_o(irq_max_o), .irq_mode_o(irq_mode_o), .irq_shv_o(irq_shv_o),
    .irq_kill_req_o(irq_kill_req_o), .irq_kill_ack_i(kill_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         vld;
    logic [3:0] id;
    logic [1:0] mode;
    logic [7:0] prio;
    bit         shv;
  } ent_t;

  ent_t          m_pipe [NP];
  ent_t          m_out;
  bit            m_kill;
  bit            m_claiming;
  logic [NS-1:0] m_claim;

  function automatic ent_t ent_zero();
    ent_t e;
    e.vld = 1'b0; e.id = 4'd0; e.mode = 2'd0; e.prio = 8'd0; e.shv = 1'b0;
    return e;
  endfunction

  // Highest {mode, prio} among eligible sources; strict '>' keeps the lowest id on ties.
  function automatic ent_t ref_root();
    ent_t r;
    int   best;
    int   key;
    r    = ent_zero();
    best = -1;
    for (int s = 0; s < NS; s++) begin
      if (ip[s] && ie[s] && (prio[s] > thresh)) begin
        key = int'(mode[s]) * 256 + int'(prio[s]);
        if (key > best) begin
          best = key; r.vld = 1'b1; r.id = 4'(s);
          r.mode = mode[s]; r.prio = prio[s]; r.shv = shv[s];
        end
      end
    end
    return r;
  endfunction

  task automatic model_step();
    ent_t          root, head, nxt;
    bit            kill_n, claiming_n;
    logic [NS-1:0] claim_n;
    root       = ref_root();
    head       = m_pipe[NP-1];
    nxt        = m_out;
    kill_n     = 1'b0;
    claiming_n = 1'b0;
    claim_n    = '0;
    if (m_claiming) begin
      claim_n[m_out.id] = 1'b1;
      nxt = ent_zero();
    end else if (!m_out.vld) begin
      nxt = head.vld ? head : ent_zero();
    end else if (!le[m_out.id] && !ip[m_out.id]) begin
      nxt = ent_zero();
    end else if (ready) begin
      nxt.vld = 1'b0;
      claiming_n = 1'b1;
    end else if (m_kill && kill_ack) begin
      nxt = ent_zero();
    end else begin
      kill_n = (head.vld && head.id != m_out.id) || (m_out.prio <= thresh);
    end
    for (int i = NP - 1; i > 0; i--) m_pipe[i] = m_claiming ? ent_zero() : m_pipe[i-1];
    m_pipe[0]  = m_claiming ? ent_zero() : root;
    m_out      = nxt;
    m_kill     = kill_n;
    m_claim    = claim_n;
    m_claiming = claiming_n;
  endtask

  task automatic clear_inputs();
    ip = '0; ie = '0; le = '0; shv = '0; prio = '0; mode = '0;
    thresh = 8'd0; ready = 1'b0; kill_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_src(input int s, input int p, input int m, input bit edge_trig);
    prio[s] = 8'(p); mode[s] = 2'(m); le[s] = edge_trig; ie[s] = 1'b1; ip[s] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    set_src(3, 9, 1, 1'b1);
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({irq_valid_o, irq_id_o, irq_max_o, irq_mode_o, irq_shv_o, irq_kill_req_o, claim_o} !== 33'd0)
      $display("FAIL reset_outputs got valid=%0b id=%0d max=%0d claim=%h want all 0",
               irq_valid_o, irq_id_o, irq_max_o, claim_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    set_src(5, 3, 0, 1'b1);
    tick(); ip[5] = 1'b0;
    n_checks++;
    if (irq_valid_o !== 1'b0) $display("FAIL lat_early1 got %0b want 0", irq_valid_o); else n_pass++;
    tick();
    n_checks++;
    if (irq_valid_o !== 1'b0) $display("FAIL lat_early2 got %0b want 0", irq_valid_o); else n_pass++;
    tick();
    n_checks++;
    if ({irq_valid_o, irq_id_o, irq_max_o, irq_kill_req_o} !== {1'b1, 4'd5, 8'd3, 1'b0})
      $display("FAIL lat_present got valid=%0b id=%0d max=%0d kill=%0b want 1/5/3/0",
               irq_valid_o, irq_id_o, irq_max_o, irq_kill_req_o);
    else n_pass++;
    tick(); ready = 1'b1;
    tick(); ready = 1'b0;
    n_checks++;
    if ({irq_valid_o, claim_o} !== {1'b0, 16'h0000})
      $display("FAIL lat_handshake got valid=%0b claim=%h want 0/0000", irq_valid_o, claim_o);
    else n_pass++;
    tick();
    n_checks++;
    if (claim_o !== 16'h0020) $display("FAIL lat_claim got %h want 0020", claim_o); else n_pass++;
    tick();
    n_checks++;
    if ({irq_valid_o, claim_o} !== {1'b0, 16'h0000})
      $display("FAIL lat_after_claim got valid=%0b claim=%h want 0/0000", irq_valid_o, claim_o);
    else n_pass++;
  endtask

  task automatic test_tiebreak();
    do_reset();
    set_src(4, 7, 3, 1'b1);
    set_src(9, 7, 3, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({irq_valid_o, irq_id_o, irq_mode_o, irq_max_o} !== {1'b1, 4'd4, 2'd3, 8'd7})
      $display("FAIL tie_lower_id got valid=%0b id=%0d mode=%0d max=%0d want 1/4/3/7",
               irq_valid_o, irq_id_o, irq_mode_o, irq_max_o);
    else n_pass++;
    do_reset();
    set_src(9, 1, 3, 1'b1);
    set_src(4, 200, 1, 1'b1);
    repeat (3) tick();
    n_checks++;
    if ({irq_valid_o, irq_id_o, irq_mode_o, irq_max_o} !== {1'b1, 4'd9, 2'd3, 8'd1})
      $display("FAIL mode_over_prio got valid=%0b id=%0d mode=%0d max=%0d want 1/9/3/1",
               irq_valid_o, irq_id_o, irq_mode_o, irq_max_o);
    else n_pass++;
  endtask

  task automatic test_preempt();
    do_reset();
    set_src(2, 4, 0, 1'b1);
    repeat (3) tick();
    set_src(7, 9, 0, 1'b1);
    repeat (2) tick();
    n_checks++;
    if ({irq_kill_req_o, irq_id_o} !== {1'b0, 4'd2})
      $display("FAIL preempt_no_kill_yet got kill=%0b id=%0d want 0/2", irq_kill_req_o, irq_id_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({irq_kill_req_o, irq_valid_o, irq_id_o} !== {1'b1, 1'b1, 4'd2})
      $display("FAIL preempt_kill got kill=%0b valid=%0b id=%0d want 1/1/2",
               irq_kill_req_o, irq_valid_o, irq_id_o);
    else n_pass++;
    kill_ack = 1'b1;
    tick(); kill_ack = 1'b0;
    n_checks++;
    if ({irq_kill_req_o, irq_valid_o} !== 2'b00)
      $display("FAIL preempt_ack got kill=%0b valid=%0b want 0/0", irq_kill_req_o, irq_valid_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({irq_valid_o, irq_id_o, irq_max_o} !== {1'b1, 4'd7, 8'd9})
      $display("FAIL preempt_represent got valid=%0b id=%0d max=%0d want 1/7/9",
               irq_valid_o, irq_id_o, irq_max_o);
    else n_pass++;
  endtask

  task automatic test_thresh_and_level();
    do_reset();
    set_src(2, 4, 0, 1'b1);
    repeat (3) tick();
    thresh = 8'd4;
    tick(); thresh = 8'd0;
    n_checks++;
    if (irq_kill_req_o !== 1'b1) $display("FAIL thresh_kill got %0b want 1", irq_kill_req_o); else n_pass++;
    tick();
    n_checks++;
    if ({irq_kill_req_o, irq_valid_o, irq_id_o} !== {1'b0, 1'b1, 4'd2})
      $display("FAIL kill_withdraw got kill=%0b valid=%0b id=%0d want 0/1/2",
               irq_kill_req_o, irq_valid_o, irq_id_o);
    else n_pass++;
    do_reset();
    set_src(3, 5, 0, 1'b0);
    repeat (3) tick();
    n_checks++;
    if ({irq_valid_o, irq_id_o} !== {1'b1, 4'd3})
      $display("FAIL level_present got valid=%0b id=%0d want 1/3", irq_valid_o, irq_id_o);
    else n_pass++;
    ip[3] = 1'b0;
    tick();
    n_checks++;
    if (irq_valid_o !== 1'b0) $display("FAIL level_drop got %0b want 0", irq_valid_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (claim_o !== 16'h0000) $display("FAIL level_no_claim got %h want 0000", claim_o); else n_pass++;
    end
  endtask

  task automatic test_ready_vs_kill();
    do_reset();
    set_src(2, 4, 0, 1'b1);
    repeat (3) tick();
    thresh = 8'd4;
    tick();
    n_checks++;
    if (irq_kill_req_o !== 1'b1) $display("FAIL rvk_kill got %0b want 1", irq_kill_req_o); else n_pass++;
    ready = 1'b1; kill_ack = 1'b1;
    tick(); ready = 1'b0; kill_ack = 1'b0;
    n_checks++;
    if ({irq_valid_o, irq_kill_req_o, claim_o} !== {2'b00, 16'h0000})
      $display("FAIL rvk_handshake got valid=%0b kill=%0b claim=%h want 0/0/0000",
               irq_valid_o, irq_kill_req_o, claim_o);
    else n_pass++;
    tick();
    n_checks++;
    if (claim_o !== 16'h0004) $display("FAIL rvk_claim got %h want 0004", claim_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_src(6, 5, 2, 1'b1);
    shv[6] = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({irq_valid_o, irq_id_o, irq_mode_o, irq_shv_o} !== {1'b1, 4'd6, 2'd2, 1'b1})
      $display("FAIL rmid_present got valid=%0b id=%0d mode=%0d shv=%0b want 1/6/2/1",
               irq_valid_o, irq_id_o, irq_mode_o, irq_shv_o);
    else n_pass++;
    ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({irq_valid_o, irq_id_o, irq_max_o, irq_mode_o, irq_shv_o, irq_kill_req_o} !== 17'd0)
      $display("FAIL rmid_async got valid=%0b id=%0d max=%0d mode=%0d shv=%0b want all 0",
               irq_valid_o, irq_id_o, irq_max_o, irq_mode_o, irq_shv_o);
    else n_pass++;
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (claim_o !== 16'h0000) $display("FAIL rmid_no_claim got %h want 0000", claim_o); else n_pass++;
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (irq_valid_o !== 1'b0) $display("FAIL rmid_relatency got %0b want 0", irq_valid_o); else n_pass++;
    tick();
    n_checks++;
    if ({irq_valid_o, irq_id_o} !== {1'b1, 4'd6})
      $display("FAIL rmid_first got valid=%0b id=%0d want 1/6", irq_valid_o, irq_id_o);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NP; i++) m_pipe[i] = ent_zero();
    m_out = ent_zero(); m_kill = 1'b0; m_claiming = 1'b0; m_claim = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) ip = 16'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) ie = 16'(~($urandom & $urandom & $urandom));
      if ($urandom_range(0, 7) == 0) le = 16'($urandom);
      if ($urandom_range(0, 7) == 0) shv = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        for (int s = 0; s < NS; s++) begin
          prio[s] = 8'($urandom_range(0, 12));
          mode[s] = 2'($urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 11) == 0) thresh = 8'($urandom_range(0, 4));
      ready    = ($urandom_range(0, 2) == 0);
      kill_ack = ($urandom_range(0, 2) == 0);
      model_step();
      @(posedge clk);
      #1;
      n_checks++;
      if ({irq_valid_o, irq_id_o, irq_mode_o, irq_max_o, irq_shv_o, irq_kill_req_o, claim_o} !==
          {m_out.vld, m_out.id, m_out.mode, m_out.prio, m_out.shv, m_kill, m_claim})
        $display("FAIL rand_cycle%0d got v=%0b id=%0d mode=%0d max=%0d shv=%0b kill=%0b claim=%h want v=%0b id=%0d mode=%0d max=%0d shv=%0b kill=%0b claim=%h",
                 c, irq_valid_o, irq_id_o, irq_mode_o, irq_max_o, irq_shv_o, irq_kill_req_o, claim_o,
                 m_out.vld, m_out.id, m_out.mode, m_out.prio, m_out.shv, m_kill, m_claim);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_latency();
    test_tiebreak();
    test_preempt();
    test_thresh_and_level();
    test_ready_vs_kill();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
